// File: rtl/ddr_wr_packer_if.sv
// Handshake/bus bundle between the user write stream and the DDR write packer.
// Master drives user words and observes the packed FIFO write; slave is the packer.
interface ddr_wr_packer_if #(
  parameter int IN_WIDTH = 16,
  parameter int LANES    = 8
);
  localparam int OUT_WIDTH = IN_WIDTH * LANES;

  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_en;
  logic [OUT_WIDTH-1:0] out_data;
  logic [LANES-1:0]     out_mask;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_en, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_en, out_data, out_mask
  );
endinterface

// File: rtl/ddr_wr_packer.sv
// Packs LANES user words into one wide DDR write-FIFO word, lane 0 in the low bits,
// matching the read-side unpacker so data reads back in the order it was written.
module ddr_wr_packer_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] merged,
  output logic         vld
);
  logic [W-1:0] data_q, data_d;
  logic         vld_q, vld_d;

  // merged is the lane as it will look after this edge, so an emit can include
  // the word being accepted on the same edge.
  always_comb begin
    merged = wr ? din : (vld_q ? data_q : '0);
    vld    = wr | vld_q;
    data_d = clr ? '0 : merged;
    vld_d  = clr ? 1'b0 : vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end
endmodule

module ddr_wr_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 128,
  parameter int LANES     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ddr_wr_packer_if.slave       bus,
  input  logic                 flush,
  input  logic                 fifo_afull,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic {EMPTY, FILL} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               lane_idx_q, lane_idx_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_en_q, out_en_d;
  logic [OUT_WIDTH-1:0]           out_data_q, out_data_d;
  logic [LANES-1:0]               out_mask_q, out_mask_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;

  logic                           accept, emit;
  logic [LANES-1:0]               lane_wr;
  logic [LANES-1:0]               lane_vld;
  logic [LANES-1:0][IN_WIDTH-1:0] lane_merged;

  assign accept = bus.in_valid & in_ready_q;
  assign busy   = (state_q == FILL);
  assign emit   = (accept & ((lane_idx_q == IDX_W'(LANES-1)) | bus.in_last))
                | (flush & (busy | accept));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_wr[g] = accept && (lane_idx_q == IDX_W'(g));
    ddr_wr_packer_lane #(.W(IN_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr     (lane_wr[g]),
      .clr    (emit),
      .din    (bus.in_data),
      .merged (lane_merged[g]),
      .vld    (lane_vld[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    in_ready_d = ~fifo_afull;
    out_en_d   = 1'b0;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    cnt_d      = cnt_q;
    if (emit) begin
      state_d    = EMPTY;
      lane_idx_d = '0;
      out_en_d   = 1'b1;
      out_data_d = lane_merged;
      out_mask_d = lane_vld;
      cnt_d      = cnt_q + CNT_WIDTH'(1);
    end else if (accept) begin
      state_d    = FILL;
      lane_idx_d = lane_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      lane_idx_q <= '0;
      in_ready_q <= 1'b0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      out_mask_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      in_ready_q <= in_ready_d;
      out_en_q   <= out_en_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.out_en   = out_en_q;
  assign bus.out_data = out_data_q;
  assign bus.out_mask = out_mask_q;
  assign word_cnt     = cnt_q;
endmodule

// File: tb/tb_ddr_wr_packer.sv
// Directed bench for ddr_wr_packer: streaming, in_last, flush, fifo_afull backpressure
// and mid-word reset, each step checked against hand-computed values.
module tb_ddr_wr_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_afull = 1'b0;
  logic [15:0] word_cnt;
  logic        busy;
  int          n_cmp = 0;
  int          n_err = 0;

  ddr_wr_packer_if #(.IN_WIDTH(16), .LANES(8)) bus ();

  ddr_wr_packer #(.IN_WIDTH(16), .OUT_WIDTH(128), .LANES(8), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .fifo_afull (fifo_afull),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last, input logic fl);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    flush        = fl;
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    flush        = 1'b0;
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_out_en", bus.out_en, 1'b0);
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_out_mask", bus.out_mask, 8'h00);
    chk("rst_word_cnt", word_cnt, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", bus.in_ready, 1'b1);

    // 16 back-to-back words -> two full packed words
    for (int i = 1; i <= 16; i++) begin
      send(16'(i), 1'b0, 1'b0);
      chk("stream_en", bus.out_en, (i == 8 || i == 16));
      if (i == 8) begin
        chk("stream_d0", bus.out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("stream_m0", bus.out_mask, 8'hFF);
        chk("stream_c0", word_cnt, 16'd1);
      end
      if (i == 16) begin
        chk("stream_d1", bus.out_data, 128'h0010_000f_000e_000d_000c_000b_000a_0009);
        chk("stream_m1", bus.out_mask, 8'hFF);
        chk("stream_c1", word_cnt, 16'd2);
      end
    end
    idle();
    chk("stream_idle_en", bus.out_en, 1'b0);
    chk("stream_idle_busy", busy, 1'b0);

    // in_last on the third word -> partial emission
    send(16'h00A1, 1'b0, 1'b0);
    send(16'h00A2, 1'b0, 1'b0);
    chk("last_busy_mid", busy, 1'b1);
    chk("last_en_mid", bus.out_en, 1'b0);
    send(16'h00A3, 1'b1, 1'b0);
    chk("last_en", bus.out_en, 1'b1);
    chk("last_data", bus.out_data, 128'h0000_0000_0000_0000_0000_00A3_00A2_00A1);
    chk("last_mask", bus.out_mask, 8'h07);
    chk("last_cnt", word_cnt, 16'd3);
    idle();
    chk("last_busy_after", busy, 1'b0);
    chk("last_en_after", bus.out_en, 1'b0);

    // 5 words then a lone flush
    for (int i = 1; i <= 5; i++) send(16'h0050 + 16'(i), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_en", bus.out_en, 1'b1);
    chk("flush_mask", bus.out_mask, 8'h1F);
    chk("flush_data", bus.out_data, 128'h0000_0000_0000_0055_0054_0053_0052_0051);
    chk("flush_cnt", word_cnt, 16'd4);
    idle();
    chk("flush_en_after", bus.out_en, 1'b0);
    chk("flush_busy_after", busy, 1'b0);

    // flush with nothing buffered
    flush = 1'b1;
    tick();
    chk("flush_empty_en", bus.out_en, 1'b0);
    chk("flush_empty_cnt", word_cnt, 16'd4);
    idle();

    // flush on the same edge as the 8th word -> one emission
    for (int i = 1; i <= 8; i++) send(16'h0060 + 16'(i), 1'b0, (i == 8));
    chk("flush8_en", bus.out_en, 1'b1);
    chk("flush8_mask", bus.out_mask, 8'hFF);
    chk("flush8_cnt", word_cnt, 16'd5);
    idle();
    chk("flush8_en_after", bus.out_en, 1'b0);
    chk("flush8_cnt_after", word_cnt, 16'd5);

    // in_last on lane 7 -> single full emission
    for (int i = 1; i <= 8; i++) send(16'h00B0 + 16'(i), (i == 8), 1'b0);
    chk("last7_en", bus.out_en, 1'b1);
    chk("last7_data", bus.out_data, 128'h00B8_00B7_00B6_00B5_00B4_00B3_00B2_00B1);
    chk("last7_mask", bus.out_mask, 8'hFF);
    idle();
    chk("last7_en_after", bus.out_en, 1'b0);
    chk("last7_cnt", word_cnt, 16'd6);

    // fifo_afull raised with lane 3 on the bus
    send(16'h0071, 1'b0, 1'b0);
    send(16'h0072, 1'b0, 1'b0);
    send(16'h0073, 1'b0, 1'b0);
    fifo_afull = 1'b1;
    send(16'h0074, 1'b0, 1'b0);
    chk("afull_ready_drop", bus.in_ready, 1'b0);
    bus.in_data = 16'h0075;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("afull_ready_held", bus.in_ready, 1'b0);
      chk("afull_no_en", bus.out_en, 1'b0);
    end
    chk("afull_busy", busy, 1'b1);
    fifo_afull = 1'b0;
    tick();
    chk("afull_ready_back", bus.in_ready, 1'b1);
    for (int i = 5; i <= 8; i++) send(16'h0070 + 16'(i), 1'b0, 1'b0);
    chk("afull_en", bus.out_en, 1'b1);
    chk("afull_data", bus.out_data, 128'h0078_0077_0076_0075_0074_0073_0072_0071);
    chk("afull_cnt", word_cnt, 16'd7);
    idle();

    // reset in the middle of a word
    for (int i = 1; i <= 4; i++) send(16'h0080 + 16'(i), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_en", bus.out_en, 1'b0);
    chk("mrst_cnt", word_cnt, 16'd0);
    chk("mrst_ready", bus.in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_ready_back", bus.in_ready, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      send(16'h0090 + 16'(i), 1'b0, 1'b0);
      chk("mrst_stream_en", bus.out_en, (i == 8));
    end
    chk("mrst_data", bus.out_data, 128'h0098_0097_0096_0095_0094_0093_0092_0091);
    chk("mrst_mask", bus.out_mask, 8'hFF);
    chk("mrst_cnt_after", word_cnt, 16'd1);
    idle();
    chk("mrst_en_after", bus.out_en, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
